// File: rtl/sync_reg_wr_arbiter.sv
// Round-robin write scheduler for a Sync_Reg CDC register: one word in flight,
// tracked through the read side via a synchronised r_empty; done/timeout reported per owner.
module sync_reg_wr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SIZE        = 8,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [SIZE-1:0]         w_data,
  output logic                    w_en,
  input  logic                    r_empty
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_FULL, WAIT_EMPTY} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [SIZE-1:0]        w_data_q, w_data_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic                   to_q, to_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   empty_s;
  logic                   found;
  logic [IW-1:0]          pick;

  // Resets to "empty" so the first request after reset is not blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], r_empty};
  end

  assign empty_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    w_data_d = w_data_q;
    done_d   = '0;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && empty_s) begin
          sel_d    = pick;
          w_data_d = req_data[int'(pick)*SIZE +: SIZE];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (int'(sel_q) == N_REQ - 1) ? '0 : sel_q + 1'b1;
        timer_d = '0;
        state_d = WAIT_FULL;
      end
      WAIT_FULL: begin
        // The awaited level is tested first so it wins over a coincident timeout.
        if (!empty_s) begin
          timer_d = '0;
          state_d = WAIT_EMPTY;
        end else if (timer_q >= TLAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_EMPTY: begin
        if (empty_s) begin
          done_d[sel_q] = 1'b1;
          state_d       = IDLE;
        end else if (timer_q >= TLAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      timer_q  <= '0;
      w_data_q <= '0;
      done_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      w_data_q <= w_data_d;
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == ISSUE) gnt[sel_q] = 1'b1;
  end

  assign w_en        = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign w_data      = w_data_q;
  assign done        = done_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_sync_reg_wr_arbiter.sv
// Directed plus randomized checks of sync_reg_wr_arbiter against a round-robin model.
module tb_sync_reg_wr_arbiter;

  localparam int N    = 4;
  localparam int SZ   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_t;
  logic [N*SZ-1:0] req_data;
  logic            r_empty, r_empty_t;
  logic [N-1:0]    gnt, done, gnt_t, done_t;
  logic            timeout_err, busy, w_en, timeout_err_t, busy_t, w_en_t;
  logic [SZ-1:0]   w_data, w_data_t;

  int vectors    = 0;
  int miscompares = 0;
  int ptr_m      = 0;
  int k;

  always #5 clk = ~clk;

  sync_reg_wr_arbiter #(.N_REQ(N), .SIZE(SZ), .TIMEOUT(255), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .timeout_err(timeout_err), .busy(busy), .w_data(w_data), .w_en(w_en), .r_empty(r_empty));

  sync_reg_wr_arbiter #(.N_REQ(N), .SIZE(SZ), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut_to (
    .clk(clk), .rst(rst), .req(req_t), .req_data(req_data), .gnt(gnt_t), .done(done_t),
    .timeout_err(timeout_err_t), .busy(busy_t), .w_data(w_data_t), .w_en(w_en_t), .r_empty(r_empty_t));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [SZ-1:0] byte_of(input int i);
    return req_data[i*SZ +: SZ];
  endfunction

  task automatic expect_grant(input string tag, input int idx);
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
    chk({tag, "_wen"}, 32'(w_en), 32'd1);
    chk({tag, "_wdata"}, 32'(w_data), 32'(byte_of(idx)));
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    ptr_m = (idx + 1) % N;
  endtask

  // Read side: drains the word d1 cycles after issue, frees it d2 cycles later.
  task automatic read_side(input string tag, input int d1, input int d2, input int idx);
    int n;
    tick();
    chk({tag, "_wen_pulse"}, 32'(w_en), 32'd0);
    chk({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
    chk({tag, "_wdata_hold"}, 32'(w_data), 32'(byte_of(idx)));
    repeat (d1 - 1) tick();
    r_empty = 1'b0;
    repeat (d2) begin
      tick();
      chk({tag, "_no_early_done"}, 32'(done | {N{timeout_err}}), 32'd0);
    end
    r_empty = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (done == '0 && n < 12);
    chk({tag, "_done_lat"}, 32'(n), 32'(SYNC + 1));
    chk({tag, "_done_idx"}, 32'(done), 32'(1 << idx));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req       = 4'b1111;
    req_t     = '0;
    r_empty   = 1'b1;
    r_empty_t = 1'b1;
    req_data  = 32'h44BB2211;

    // Reset holds everything quiet even with all requests up.
    repeat (3) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wen", 32'(w_en), 32'd0);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata", 32'(w_data), 32'd0);
    chk("rst_done", 32'(done | {N{timeout_err}}), 32'd0);
    rst = 1'b1;
    expect_grant("t1", 0);
    req = '0;
    read_side("t1", 2, 2, 0);

    req = 4'b0100;
    expect_grant("t2", rr_pick(ptr_m, req));
    chk("t2_gnt_onehot", 32'(gnt), 32'h4);
    req = '0;
    read_side("t2", 5, 20, 2);

    // Fairness from a fresh reset with every requester active.
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("t3_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_grant("t3", i % N);
      chk("t3_model", 32'(i % N), 32'(rr_pick(i % N, req)));
      read_side("t3", 1, 1, i % N);
    end
    req = '0;

    req_t = 4'b0011;
    tick();
    chk("t4_gnt", 32'(gnt_t), 32'h1);
    chk("t4_wen", 32'(w_en_t), 32'd1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!timeout_err_t && k < 40);
    chk("t4_to_lat", 32'(k), 32'(TO + 1));
    chk("t4_to_pulse", 32'(timeout_err_t), 32'd1);
    chk("t4_no_done", 32'(done_t), 32'd0);
    chk("t4_idle", 32'(busy_t), 32'd0);
    tick();
    chk("t4_next_gnt", 32'(gnt_t), 32'h2);
    chk("t4_to_once", 32'(timeout_err_t), 32'd0);
    req_t = '0;

    // A stale word on the read side blocks issue until it drains.
    r_empty = 1'b0;
    repeat (3) tick();
    req = 4'b0010;
    repeat (5) begin
      tick();
      chk("t5_blocked", 32'({gnt, busy}), 32'd0);
    end
    r_empty = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (gnt == '0 && k < 10);
    chk("t5_lat", 32'(k <= SYNC + 2), 32'd1);
    chk("t5_gnt", 32'(gnt), 32'h2);
    chk("t5_wdata", 32'(w_data), 32'(byte_of(1)));
    ptr_m = 2;
    req = '0;
    read_side("t5", 1, 1, 1);

    req = 4'b0100;
    expect_grant("t6", rr_pick(ptr_m, req));
    req = '0;
    tick();
    r_empty = 1'b0;
    repeat (4) tick();
    chk("t6_wait_empty", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async", 32'({busy, w_en, gnt, done, timeout_err}), 32'd0);
    chk("t6_wdata", 32'(w_data), 32'd0);
    r_empty = 1'b1;
    req = 4'b1000;
    tick();
    tick();
    chk("t6_held", 32'({busy, gnt}), 32'd0);
    rst = 1'b1;
    expect_grant("t6_rst", rr_pick(0, req));
    req = '0;
    read_side("t6", 2, 3, 3);

    // Random traffic: request sets, data and read-side delays; req may drop mid-flight.
    for (int it = 0; it < 40; it++) begin
      int idx;
      req_data = $urandom();
      req      = 4'($urandom_range(1, 15));
      idx      = rr_pick(ptr_m, req);
      expect_grant("rnd", idx);
      req = 4'($urandom_range(0, 15));
      read_side("rnd", int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), idx);
    end
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_reg_wr_arbiter.md
Name: sync_reg_wr_arbiter

Overview:
Write-side scheduler for the Sync_Reg clock-domain-crossing register. It shares the single Sync_Reg write port between N_REQ requesters in the write clock domain using round-robin arbitration. It issues one write at a time and tracks the word through the read domain by synchronising r_empty back. It reports completion or timeout to the owning requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
SIZE, 8, data width; must match Sync_Reg SIZE
TIMEOUT, 255, max cycles spent in each wait state before abort (1..65535)
SYNC_STAGES, 2, flops in the r_empty synchroniser (>=2)

Ports:
clk  input  1  write-domain clock; drives Sync_Reg w_clk
rst  input  1  asynchronous, active-low reset
req  input  N_REQ  level request per requester
req_data  input  N_REQ*SIZE  requester i data at bits [i*SIZE +: SIZE]
gnt  output  N_REQ  one-hot, one-cycle pulse: requester's data taken
done  output  N_REQ  one-hot, one-cycle pulse: word consumed by read side
timeout_err  output  1  one-cycle pulse: transaction aborted
busy  output  1  high in every state except IDLE
w_data  output  SIZE  to Sync_Reg w_data
w_en  output  1  to Sync_Reg w_en, one-cycle pulse
r_empty  input  1  from Sync_Reg r_empty, asynchronous to clk

Behaviour:
- Reset (rst=0, async): FSM=IDLE; gnt, done, timeout_err, w_en, busy=0; w_data=0; rr pointer=0; timer=0; synchroniser flops=1 (empty).
- The synchroniser takes r_empty into empty_s after SYNC_STAGES clk edges. Only empty_s is used internally.
- All outputs are registered or decoded from state only. No combinational path from req to any output.
- States are IDLE, ISSUE, WAIT_FULL, WAIT_EMPTY.
- IDLE: if any req=1 and empty_s=1, select the first requesting index searching ptr, ptr+1, ... (mod N_REQ). Latch the index in sel, then go to ISSUE.
  - If empty_s=0 in IDLE, stay there. A stale word is pending, so do not issue.
- ISSUE (exactly 1 cycle):
  - w_en=1; w_data=req_data[sel] (registered on IDLE->ISSUE edge); gnt[sel]=1.
  - ptr <= sel+1 mod N_REQ; timer cleared; go to WAIT_FULL.
- WAIT_FULL: wait for empty_s=0.
  - On empty_s=0: go to WAIT_EMPTY and clear timer.
  - When timer reaches TIMEOUT: pulse timeout_err and go to IDLE.
- WAIT_EMPTY: wait for empty_s=1.
  - On empty_s=1: pulse done[sel] for 1 cycle, coincident with the transition to IDLE.
  - When timer reaches TIMEOUT: pulse timeout_err, no done, go to IDLE.
- Timer: ceil(log2(TIMEOUT+1)) bits; increments each cycle in a wait state; saturates and never wraps.
- w_data holds its value after ISSUE until the next ISSUE.
- Latency: req sampled high in IDLE at edge k gives gnt/w_en high during cycle k+1. The earliest next grant comes one cycle after done.
- Requests are level-sensitive and not queued. A requester holding req after gnt is a fresh request that is eligible only at the next IDLE evaluation, subject to rr order.
- Fairness: with all req held high, grant order is 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 grants.
- Simultaneous events:
  - req and empty_s=0 in the same IDLE cycle: no grant.
  - TIMEOUT reached on the same cycle as the awaited empty_s level: the success transition wins.
- Reset mid-operation: the transaction is dropped and no done/timeout_err is emitted. Outputs take reset values within the same cycle.
- req deasserted after sel is latched does not cancel an in-flight transaction.

Test Plan:
1. Reset with req=4'b1111, then release; hold r_empty=1 -> no gnt/w_en while rst=0; after release gnt=4'b0001 first, w_data=req_data[0].
2. Single requester 2 with data 8'hBB; drive r_empty 1->0 after 5 cycles and 0->1 after 20 cycles -> w_en pulse 1 cycle with w_data=8'hBB; gnt=4'b0100; done=4'b0100 exactly once, SYNC_STAGES+1 cycles after r_empty rises.
3. All four req held high, model read side returning empty promptly -> grant sequence 0,1,2,3,0,1; never two gnt bits set.
4. TIMEOUT=10, r_empty held 1 after issue -> timeout_err pulses at the 10th WAIT_FULL cycle; no done; FSM in IDLE; next requester is granted.
5. r_empty held 0 at start with req[1]=1 -> no grant; after r_empty rises, gnt[1] within SYNC_STAGES+2 cycles.
6. Assert rst=0 during WAIT_EMPTY -> w_en, gnt, done, busy=0 immediately; after release with r_empty=1 and req[3]=1 -> gnt=4'b1000, restarting from ptr=0 order.
